// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: default widths, the
// occupancy state encoding and the default-width result payload.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Occupancy of a two-entry stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] aluout;
    logic [DEF_ADDR_W-1:0] ws;
    logic                  we;
  } payload_t;

endpackage

// File: rtl/fwd_match.sv
// Single-operand forwarding comparator: flags that a held result targets
// the register an upstream operand is reading.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter bit ZERO_REG_FWD = 1'b0
) (
  input  logic              vld,
  input  logic              we,
  input  logic [ADDR_W-1:0] ws,
  input  logic [ADDR_W-1:0] rs,
  output logic              hit
);

  // Register 0 is hard-wired on most cores, so it only matches when allowed.
  assign hit = vld & we & (ws == rs) & (ZERO_REG_FWD | (ws != '0));

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic execute-to-writeback stage register with a two-entry skid buffer,
// synchronous flush, operand forwarding match and a saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int CNT_W        = 16,
  parameter bit ZERO_REG_FWD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [ADDR_W-1:0] in_ws,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluout,
  output logic [ADDR_W-1:0] out_ws,
  output logic              out_we,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] aluout;
    logic [ADDR_W-1:0] ws;
    logic              we;
  } entry_t;

  stage_state_t     state_p1, state_nx;
  entry_t           main_p1, skid_p1, in_entry;
  logic             main_vld_p1, skid_vld_p1;
  logic             accept, consume;
  logic             ld_main_in, ld_main_skid, ld_skid;
  logic [CNT_W-1:0] stall_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_entry    = {in_aluout, in_ws, in_we};
  assign main_vld_p1 = (state_p1 != EMPTY);
  assign skid_vld_p1 = (state_p1 == FULL2);

  // Ready comes only from registered occupancy, never from out_ready.
  assign in_ready  = ~skid_vld_p1;
  assign accept    = in_valid & in_ready;
  assign consume   = main_vld_p1 & out_ready;

  assign out_valid  = main_vld_p1;
  assign out_aluout = main_p1.aluout;
  assign out_ws     = main_p1.ws;
  assign out_we     = main_p1.we;
  assign stall_cnt  = stall_p1;

  // Next occupancy and which payload register loads from where.
  always_comb begin
    state_nx     = state_p1;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nx   = FULL1;
        end
      end
      FULL1: begin
        if (accept && consume) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid  = 1'b1;
          state_nx = FULL2;
        end else if (consume) begin
          state_nx = EMPTY;
        end
      end
      FULL2: begin
        if (consume) begin
          ld_main_skid = 1'b1;
          state_nx     = FULL1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Flush drops everything, including a same-cycle accept; payloads may stay stale.
    if (flush) state_nx = EMPTY;
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= EMPTY;
    else     state_p1 <= state_nx;
  end

  // Main and skid payload registers; main refills from skid so order is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (ld_main_in)        main_p1 <= in_entry;
      else if (ld_main_skid) main_p1 <= skid_p1;
      if (ld_skid)           skid_p1 <= in_entry;
    end
  end

  // Back-pressure counter: saturates, survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                         stall_p1 <= '0;
    else if (main_vld_p1 && !out_ready) stall_p1 <= sat_inc(stall_p1);
  end

  fwd_match #(.ADDR_W(ADDR_W), .ZERO_REG_FWD(ZERO_REG_FWD)) u_fwd_a (
    .vld (main_vld_p1),
    .we  (main_p1.we),
    .ws  (main_p1.ws),
    .rs  (rs_a),
    .hit (fwd_hit_a)
  );

  fwd_match #(.ADDR_W(ADDR_W), .ZERO_REG_FWD(ZERO_REG_FWD)) u_fwd_b (
    .vld (main_vld_p1),
    .we  (main_p1.we),
    .ws  (main_p1.ws),
    .rs  (rs_b),
    .hit (fwd_hit_b)
  );

endmodule
